// File: rtl/tdc_readout_pkg.sv
// Shared types and constants for the tdc_64 readout controller.
// Holds the FSM state encoding, the result flag bit positions and the count-width helper.
package tdc_readout_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    WAIT   = 3'd2,
    SAMPLE = 3'd3,
    DECODE = 3'd4,
    DONE   = 3'd5
  } tdc_state_e;

  localparam int FLAG_UNDERFLOW = 0;
  localparam int FLAG_OVERFLOW  = 1;
  localparam int FLAG_BUBBLE    = 2;
  localparam int FLAG_UNSTABLE  = 3;

  // Width that can hold every count from 0 to w inclusive.
  function automatic int calc_cw(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/tdc_chunk_decode.sv
// Combinational decode of one thermometer-code slice.
// Produces the slice's popcount, whether it contains a zero, and where its lowest zero sits.
module tdc_chunk_decode #(
  parameter int CHUNK_WIDTH = 36,
  parameter int PW          = $clog2(CHUNK_WIDTH + 1),
  parameter int ZW          = (CHUNK_WIDTH > 1) ? $clog2(CHUNK_WIDTH) : 1
) (
  input  logic [CHUNK_WIDTH-1:0] chunk,
  output logic [PW-1:0]          pop,
  output logic                   has_zero,
  output logic [ZW-1:0]          zero_idx
);

  // Popcount of the slice.
  always_comb begin
    pop = {PW{1'b0}};
    for (int i = 0; i < CHUNK_WIDTH; i++) begin
      pop = pop + PW'(chunk[i]);
    end
  end

  // Scan from the top down so the lowest zero is the one that sticks.
  always_comb begin
    zero_idx = {ZW{1'b0}};
    for (int i = CHUNK_WIDTH - 1; i >= 0; i--) begin
      if (!chunk[i]) begin
        zero_idx = ZW'(i);
      end else begin
        zero_idx = zero_idx;
      end
    end
  end

  assign has_zero = ~(&chunk);

endmodule

// File: rtl/tdc_readout.sv
// Readout controller for the tdc_64 delay-line TDC: arms it, waits the window,
// double-captures the thermometer code and decodes it chunk by chunk.
module tdc_readout
  import tdc_readout_pkg::*;
#(
  parameter int DATA_WIDTH  = 252,
  parameter int CHUNK_WIDTH = 36,
  parameter int WAIT_CYCLES = 16
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             start_valid,
  output logic                             start_ready,
  output logic                             tdc_reset_b,
  input  logic [DATA_WIDTH-1:0]            code,
  output logic                             result_valid,
  input  logic                             result_ready,
  output logic [calc_cw(DATA_WIDTH)-1:0]   result_count,
  output logic [calc_cw(DATA_WIDTH)-1:0]   result_edge,
  output logic [3:0]                       result_flags
);

  localparam int CW         = calc_cw(DATA_WIDTH);
  localparam int PW         = $clog2(CHUNK_WIDTH + 1);
  localparam int ZW         = (CHUNK_WIDTH > 1) ? $clog2(CHUNK_WIDTH) : 1;
  localparam int NUM_CHUNKS = DATA_WIDTH / CHUNK_WIDTH;
  localparam int KW         = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam int TW         = $clog2(WAIT_CYCLES + 2);

  localparam logic [TW-1:0] CLEAR_LAST  = TW'(1);
  localparam logic [TW-1:0] WAIT_LAST   = TW'(WAIT_CYCLES - 1);
  localparam logic [KW-1:0] CHUNK_LAST  = KW'(NUM_CHUNKS - 1);
  localparam logic [CW-1:0] EDGE_NONE   = CW'(DATA_WIDTH);

  tdc_state_e              state_q, state_d;
  logic [TW-1:0]           timer_q, timer_d;
  logic [KW-1:0]           chunk_idx_q, chunk_idx_d;
  logic [DATA_WIDTH-1:0]   cap0_q, cap0_d;
  logic [DATA_WIDTH-1:0]   cap1_q, cap1_d;
  logic [CW-1:0]           count_q, count_d;
  logic [CW-1:0]           edge_q, edge_d;
  logic                    tdc_reset_b_q, tdc_reset_b_d;
  logic                    result_valid_q, result_valid_d;
  logic [CW-1:0]           result_count_q, result_count_d;
  logic [CW-1:0]           result_edge_q, result_edge_d;
  logic [3:0]              result_flags_q, result_flags_d;

  logic [CHUNK_WIDTH-1:0]  chunks_s [NUM_CHUNKS];
  logic [CHUNK_WIDTH-1:0]  cur_chunk_s;
  logic [PW-1:0]           chunk_pop_s;
  logic                    chunk_has_zero_s;
  logic [ZW-1:0]           chunk_zero_idx_s;
  logic [CW-1:0]           chunk_base_s;
  logic [3:0]              flags_s;

  for (genvar g = 0; g < NUM_CHUNKS; g++) begin : g_chunks
    assign chunks_s[g] = cap1_q[g*CHUNK_WIDTH +: CHUNK_WIDTH];
  end

  assign cur_chunk_s  = chunks_s[chunk_idx_q];
  assign chunk_base_s = CW'(CW'(chunk_idx_q) * CW'(CHUNK_WIDTH));

  tdc_chunk_decode #(
    .CHUNK_WIDTH (CHUNK_WIDTH),
    .PW          (PW),
    .ZW          (ZW)
  ) u_chunk_decode (
    .chunk    (cur_chunk_s),
    .pop      (chunk_pop_s),
    .has_zero (chunk_has_zero_s),
    .zero_idx (chunk_zero_idx_s)
  );

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d        = state_q;
    timer_d        = timer_q;
    chunk_idx_d    = chunk_idx_q;
    cap0_d         = cap0_q;
    cap1_d         = cap1_q;
    count_d        = count_q;
    edge_d         = edge_q;
    result_valid_d = result_valid_q;
    result_count_d = result_count_q;
    result_edge_d  = result_edge_q;
    result_flags_d = result_flags_q;
    flags_s        = 4'b0000;

    case (state_q)
      IDLE: begin
        if (start_valid) begin
          state_d = CLEAR;
          timer_d = {TW{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      CLEAR: begin
        if (timer_q == CLEAR_LAST) begin
          state_d = WAIT;
          timer_d = {TW{1'b0}};
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      WAIT: begin
        // The edge that leaves WAIT is the first capture edge.
        if (timer_q == WAIT_LAST) begin
          state_d = SAMPLE;
          timer_d = {TW{1'b0}};
          cap0_d  = code;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      SAMPLE: begin
        if (timer_q == {TW{1'b0}}) begin
          cap1_d  = code;
          timer_d = TW'(1);
        end else begin
          state_d     = DECODE;
          chunk_idx_d = {KW{1'b0}};
          count_d     = {CW{1'b0}};
          edge_d      = EDGE_NONE;
        end
      end
      DECODE: begin
        count_d = count_q + CW'(chunk_pop_s);
        if (chunk_has_zero_s && (edge_q == EDGE_NONE)) begin
          edge_d = chunk_base_s + CW'(chunk_zero_idx_s);
        end else begin
          edge_d = edge_q;
        end
        if (chunk_idx_q == CHUNK_LAST) begin
          flags_s[FLAG_UNDERFLOW] = (count_d == {CW{1'b0}});
          flags_s[FLAG_OVERFLOW]  = (count_d == CW'(DATA_WIDTH));
          flags_s[FLAG_BUBBLE]    = (count_d != edge_d);
          flags_s[FLAG_UNSTABLE]  = (cap0_q != cap1_q);
          state_d        = DONE;
          result_valid_d = 1'b1;
          result_count_d = count_d;
          result_edge_d  = edge_d;
          result_flags_d = flags_s;
        end else begin
          chunk_idx_d = chunk_idx_q + KW'(1);
        end
      end
      DONE: begin
        if (result_ready) begin
          state_d        = IDLE;
          result_valid_d = 1'b0;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d        = IDLE;
        result_valid_d = 1'b0;
      end
    endcase

    tdc_reset_b_d = (state_d != CLEAR);
  end

  // State and datapath registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      timer_q        <= {TW{1'b0}};
      chunk_idx_q    <= {KW{1'b0}};
      cap0_q         <= {DATA_WIDTH{1'b0}};
      cap1_q         <= {DATA_WIDTH{1'b0}};
      count_q        <= {CW{1'b0}};
      edge_q         <= {CW{1'b0}};
      tdc_reset_b_q  <= 1'b0;
      result_valid_q <= 1'b0;
      result_count_q <= {CW{1'b0}};
      result_edge_q  <= {CW{1'b0}};
      result_flags_q <= 4'b0000;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      chunk_idx_q    <= chunk_idx_d;
      cap0_q         <= cap0_d;
      cap1_q         <= cap1_d;
      count_q        <= count_d;
      edge_q         <= edge_d;
      tdc_reset_b_q  <= tdc_reset_b_d;
      result_valid_q <= result_valid_d;
      result_count_q <= result_count_d;
      result_edge_q  <= result_edge_d;
      result_flags_q <= result_flags_d;
    end
  end

  assign start_ready  = (state_q == IDLE);
  assign tdc_reset_b  = tdc_reset_b_q;
  assign result_valid = result_valid_q;
  assign result_count = result_count_q;
  assign result_edge  = result_edge_q;
  assign result_flags = result_flags_q;

endmodule

// File: tb/tb_tdc_readout.sv
// Scoreboard bench for tdc_readout: directed codes with hand-computed results,
// checked by a monitor at every result handshake.
module tb_tdc_readout;

  localparam int DW = 252;

  typedef struct packed {
    logic [7:0] cnt;
    logic [7:0] edg;
    logic [3:0] flg;
  } exp_t;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start_valid = 1'b0;
  logic          start_ready;
  logic          tdc_reset_b;
  logic [DW-1:0] code = '0;
  logic          result_valid;
  logic          result_ready = 1'b1;
  logic [7:0]    result_count;
  logic [7:0]    result_edge;
  logic [3:0]    result_flags;

  int   tests_run = 0;
  int   tests_failed = 0;
  exp_t exp_q[$];

  tdc_readout dut (
    .clock        (clock),
    .reset        (reset),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .tdc_reset_b  (tdc_reset_b),
    .code         (code),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result_count (result_count),
    .result_edge  (result_edge),
    .result_flags (result_flags)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] ones_low(input int n);
    logic [DW-1:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v[i] = 1'b1;
    return v;
  endfunction

  // Monitor: every accepted result is compared against the oldest expectation.
  always @(negedge clock) begin
    if (!reset && result_valid && result_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("result_count", int'(result_count), int'(e.cnt));
        check("result_edge",  int'(result_edge),  int'(e.edg));
        check("result_flags", int'(result_flags), int'(e.flg));
      end
    end
  end

  // One measurement. change_at: cycle after which code switches to code_b (-1: never).
  // stall: cycles result_ready is held low in DONE. abort_at: cycle at which reset hits (-1: never).
  task automatic measure(input logic [DW-1:0] code_a, input logic [DW-1:0] code_b,
                         input int change_at, input int stall, input int abort_at,
                         input exp_t e);
    bit done;
    done = 1'b0;
    @(negedge clock);
    code = code_a;
    result_ready = (stall == 0);
    start_valid = 1'b1;
    @(posedge clock);
    #1 start_valid = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clock);
      if (c == change_at) code = code_b;
      if (c < 2) check("tdc_reset_b_clear", int'(tdc_reset_b), 0);
      else if (c == 2) check("tdc_reset_b_release", int'(tdc_reset_b), 1);
      if (c == abort_at) begin
        reset = 1'b1;
        #1;
        check("abort_start_ready", int'(start_ready), 1);
        check("abort_tdc_reset_b", int'(tdc_reset_b), 0);
        check("abort_valid", int'(result_valid), 0);
        check("abort_count", int'(result_count), 0);
        check("abort_edge",  int'(result_edge), 0);
        check("abort_flags", int'(result_flags), 0);
        @(negedge clock);
        reset = 1'b0;
        return;
      end
      if (result_valid) begin
        done = 1'b1;
        check("latency", c, 27);
        break;
      end
    end
    if (!done) begin
      check("result_timeout", 0, 1);
      return;
    end
    for (int s = 0; s < stall; s++) begin
      check("stall_valid", int'(result_valid), 1);
      check("stall_count", int'(result_count), int'(e.cnt));
      check("stall_edge",  int'(result_edge),  int'(e.edg));
      check("stall_flags", int'(result_flags), int'(e.flg));
      check("stall_start_ready", int'(start_ready), 0);
      @(posedge clock);
      #2 start_valid = (s == 4);
      @(negedge clock);
    end
    if (stall > 0) begin
      @(posedge clock);
      #2;
      start_valid = 1'b0;
      result_ready = 1'b1;
      @(posedge clock);
      @(negedge clock);
      check("post_hs_start_ready", int'(start_ready), 1);
      check("post_hs_valid", int'(result_valid), 0);
      for (int i = 0; i < 3; i++) begin
        @(negedge clock);
        check("ignored_start_tdc", int'(tdc_reset_b), 1);
      end
    end else begin
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    logic [DW-1:0] bub;
    exp_t e;

    #2;
    check("rst_tdc_reset_b", int'(tdc_reset_b), 0);
    check("rst_valid", int'(result_valid), 0);
    check("rst_count", int'(result_count), 0);
    check("rst_edge",  int'(result_edge), 0);
    check("rst_flags", int'(result_flags), 0);
    check("rst_start_ready", int'(start_ready), 1);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("idle_tdc_reset_b", int'(tdc_reset_b), 1);

    e = '{cnt: 8'd100, edg: 8'd100, flg: 4'b0000};
    exp_q.push_back(e); measure(ones_low(100), '0, -1, 0, -1, e);

    e = '{cnt: 8'd0, edg: 8'd0, flg: 4'b0001};
    exp_q.push_back(e); measure('0, '0, -1, 0, -1, e);

    e = '{cnt: 8'd252, edg: 8'd252, flg: 4'b0010};
    exp_q.push_back(e); measure(ones_low(252), '0, -1, 0, -1, e);

    bub = ones_low(100);
    bub[50] = 1'b0;
    bub[101] = 1'b1;
    e = '{cnt: 8'd100, edg: 8'd50, flg: 4'b0100};
    exp_q.push_back(e); measure(bub, '0, -1, 0, -1, e);

    e = '{cnt: 8'd36, edg: 8'd36, flg: 4'b0000};
    exp_q.push_back(e); measure(ones_low(36), '0, -1, 0, -1, e);

    e = '{cnt: 8'd251, edg: 8'd251, flg: 4'b0000};
    exp_q.push_back(e); measure(ones_low(251), '0, -1, 0, -1, e);

    // Code moves between the two capture edges (after E18, before E19).
    e = '{cnt: 8'd100, edg: 8'd100, flg: 4'b1000};
    exp_q.push_back(e); measure(ones_low(99), ones_low(100), 18, 0, -1, e);

    e = '{cnt: 8'd72, edg: 8'd72, flg: 4'b0000};
    exp_q.push_back(e); measure(ones_low(72), '0, -1, 10, -1, e);

    // Reset during DECODE chunk 3 (cycle after E23); no result expected.
    e = '{cnt: 8'd0, edg: 8'd0, flg: 4'b0000};
    measure(ones_low(100), '0, -1, 0, 23, e);

    e = '{cnt: 8'd200, edg: 8'd200, flg: 4'b0000};
    exp_q.push_back(e); measure(ones_low(200), '0, -1, 0, -1, e);

    repeat (3) @(negedge clock);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
